// File: rtl/p405s_srm_mask_seq_if.sv
// ---------------------------------------------------------------------------
// p405s_srm_mask_seq_if
//   Bundle of every handshake and datapath signal between the SRM mask
//   sequencer, its op source, the external mask-propagate block and the
//   EXE result mux. Bit ordering is big-endian: index 0 is the MSB.
//
//   Request side   : reqVld, reqRdy, reqOp[0:1], reqMb[0:4], reqMe[0:4],
//                    reqSh[0:5], flush
//   Mask block side: mskBegin[0:31], mskEndHi[0:14], mskEndLo[16:30],
//                    propLookAhd[0:1] (to block), notMask[0:31] (from block)
//   Result side    : rsltVld, rsltHold, rsltMask[0:31], rsltSraFill, rsltZero
//
//   Modport slave  : the sequencer itself.
//   Modport master : the environment (op source, mask block, result consumer).
// ---------------------------------------------------------------------------
interface p405s_srm_mask_seq_if;
  logic         reqVld;
  logic         reqRdy;
  logic [0:1]   reqOp;
  logic [0:4]   reqMb;
  logic [0:4]   reqMe;
  logic [0:5]   reqSh;
  logic         flush;
  logic [0:31]  mskBegin;
  logic [0:14]  mskEndHi;
  logic [16:30] mskEndLo;
  logic [0:1]   propLookAhd;
  logic [0:31]  notMask;
  logic         rsltVld;
  logic         rsltHold;
  logic [0:31]  rsltMask;
  logic         rsltSraFill;
  logic         rsltZero;

  modport slave (
    input  reqVld, reqOp, reqMb, reqMe, reqSh, flush, notMask, rsltHold,
    output reqRdy, mskBegin, mskEndHi, mskEndLo, propLookAhd,
           rsltVld, rsltMask, rsltSraFill, rsltZero
  );

  modport master (
    output reqVld, reqOp, reqMb, reqMe, reqSh, flush, notMask, rsltHold,
    input  reqRdy, mskBegin, mskEndHi, mskEndLo, propLookAhd,
           rsltVld, rsltMask, rsltSraFill, rsltZero
  );
endinterface

// File: rtl/p405s_srm_mask_seq.sv
// ---------------------------------------------------------------------------
// p405s_srm_mask_seq
//   Two-stage sequencer for the SRM rotate/mask-propagation datapath. An op
//   (rlw with MB/ME, or slw/srw/sraw with a shift amount) is decoded into a
//   begin/end pair on accept. Stage 1 drives the one-hot begin/end vectors
//   and two half-word look-ahead carries into the external mask-propagate
//   block. Stage 2 registers the returned mask for the EXE result mux.
//   Big-endian bit numbering throughout: bit 0 is the MSB.
//
//   Ports
//     CB      in  core clock
//     resetL  in  asynchronous reset, active low
//     seqIf   slave modport of p405s_srm_mask_seq_if (request, mask block
//             and result signals)
//     mskErr  out sticky mask-checker error (only with P405S_SRM_MASK_CHK_EN)
//
//   Configuration
//     P405S_SRM_MASK_CHK_EN : when defined, adds a behavioural checker that
//     recomputes MASK(MB,ME) in stage 1 and compares it against ~notMask,
//     reporting on the extra mskErr output. When undefined, neither the
//     checker nor the port exists and the datapath is unchanged.
// ---------------------------------------------------------------------------
module p405s_srm_mask_seq (
  input  logic                 CB,
  input  logic                 resetL,
`ifdef P405S_SRM_MASK_CHK_EN
  output logic                 mskErr,
`endif
  p405s_srm_mask_seq_if.slave  seqIf
);

  typedef enum logic [1:0] {
    OP_RLW  = 2'b00,
    OP_SLW  = 2'b01,
    OP_SRW  = 2'b10,
    OP_SRAW = 2'b11
  } opE;

  opE         w_op;
  logic [4:0] w_decMb;
  logic [4:0] w_decMe;
  logic       w_decZero;
  logic       w_decSra;

  logic       r_live;
  logic       r_s1Vld;
  logic [4:0] r_s1Mb;
  logic [4:0] r_s1Me;
  logic       r_s1Zero;
  logic       r_s1Sra;

  logic        r_rsltVld;
  logic [0:31] r_rsltMask;
  logic        r_rsltSra;
  logic        r_rsltZero;

  logic        w_s2Frozen;
  logic        w_s1Adv;
  logic        w_rdy;
  logic        w_accept;

  logic        w_wrap;
  logic        w_bit16In;
  logic [0:31]  w_begin;
  logic [0:14]  w_endHi;
  logic [16:30] w_endLo;
  logic [0:1]   w_la;

  // Turn the incoming op into a (MB,ME) pair. Left shifts keep ones from bit 0
  // up to 31-sh, right shifts keep ones from sh down to bit 31. Any shift of
  // 32 or more leaves no surviving bits, which is carried as a zero flag.
  always_comb begin
    w_op      = opE'(seqIf.reqOp);
    w_decMb   = 5'd0;
    w_decMe   = 5'd31;
    w_decZero = 1'b0;
    w_decSra  = 1'b0;
    case (w_op)
      OP_RLW: begin
        w_decMb = seqIf.reqMb;
        w_decMe = seqIf.reqMe;
      end
      OP_SLW: begin
        w_decMe   = 5'd31 - seqIf.reqSh[1:5];
        w_decZero = seqIf.reqSh[0];
      end
      OP_SRW: begin
        w_decMb   = seqIf.reqSh[1:5];
        w_decZero = seqIf.reqSh[0];
      end
      default: begin
        w_decMb   = seqIf.reqSh[1:5];
        w_decZero = seqIf.reqSh[0];
        w_decSra  = 1'b1;
      end
    endcase
  end

  // Pipeline handshake. Stage 2 freezes while its result is held downstream;
  // stage 1 may only move into an empty or draining stage 2, and a new op is
  // taken whenever stage 1 is empty or moving. r_live keeps ready low until
  // the first clock after reset so no output depends combinationally on reset.
  assign w_s2Frozen = r_rsltVld & seqIf.rsltHold;
  assign w_s1Adv    = r_s1Vld & ~w_s2Frozen;
  assign w_rdy      = r_live & (~r_s1Vld | w_s1Adv);
  assign w_accept   = seqIf.reqVld & w_rdy & ~seqIf.flush;

  // Stage 1 holds the decoded op. Flush empties it and also swallows any op
  // offered in the same cycle; otherwise it reloads whenever ready was high.
  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      r_live   <= 1'b0;
      r_s1Vld  <= 1'b0;
      r_s1Mb   <= 5'd0;
      r_s1Me   <= 5'd0;
      r_s1Zero <= 1'b0;
      r_s1Sra  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (seqIf.flush) begin
        r_s1Vld <= 1'b0;
      end else if (w_rdy) begin
        r_s1Vld <= w_accept;
      end
      if (w_accept) begin
        r_s1Mb   <= w_decMb;
        r_s1Me   <= w_decMe;
        r_s1Zero <= w_decZero;
        r_s1Sra  <= w_decSra;
      end
    end
  end

  // Stage 1 drive towards the mask block. Begin and end are one-hot; the end
  // vectors have no slot at bits 15 and 31 because a run ending at the last
  // bit of a half-word needs no terminator. The look-ahead carries seed each
  // half-word: bit 0 starts set only for a wrapped mask, and bit 16 starts set
  // when it lies inside the mask but is not itself the begin bit (the begin
  // one-hot already sets it). Zero-flagged ops suppress begin and carries so
  // the mask block returns nothing.
  always_comb begin
    w_begin   = '0;
    w_endHi   = '0;
    w_endLo   = '0;
    w_la      = '0;
    w_wrap    = r_s1Mb > r_s1Me;
    w_bit16In = w_wrap ? ((r_s1Me >= 5'd16) || (r_s1Mb <= 5'd16))
                       : ((r_s1Mb <= 5'd16) && (r_s1Me >= 5'd16));
    if (r_s1Vld) begin
      for (int i = 0; i < 32; i++) begin
        w_begin[i] = ~r_s1Zero & (r_s1Mb == i[4:0]);
      end
      for (int i = 0; i < 15; i++) begin
        w_endHi[i] = (r_s1Me == i[4:0]);
      end
      for (int i = 16; i < 31; i++) begin
        w_endLo[i] = (r_s1Me == i[4:0]);
      end
      w_la[0] = ~r_s1Zero & w_wrap;
      w_la[1] = ~r_s1Zero & w_bit16In & (r_s1Mb != 5'd16);
    end
  end

  // Stage 2 captures the mask block's answer. Flush wins over hold; while the
  // result is held everything here stays frozen.
  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      r_rsltVld  <= 1'b0;
      r_rsltMask <= '0;
      r_rsltSra  <= 1'b0;
      r_rsltZero <= 1'b0;
    end else if (seqIf.flush) begin
      r_rsltVld <= 1'b0;
    end else if (!w_s2Frozen) begin
      r_rsltVld <= r_s1Vld;
      if (r_s1Vld) begin
        r_rsltMask <= ~seqIf.notMask;
        r_rsltSra  <= r_s1Sra;
        r_rsltZero <= r_s1Zero;
      end
    end
  end

  assign seqIf.reqRdy      = w_rdy;
  assign seqIf.mskBegin    = w_begin;
  assign seqIf.mskEndHi    = w_endHi;
  assign seqIf.mskEndLo    = w_endLo;
  assign seqIf.propLookAhd = w_la;
  assign seqIf.rsltVld     = r_rsltVld;
  assign seqIf.rsltMask    = r_rsltMask;
  assign seqIf.rsltSraFill = r_rsltSra;
  assign seqIf.rsltZero    = r_rsltZero;

`ifdef P405S_SRM_MASK_CHK_EN
  logic [0:31] w_chkMask;
  logic        r_mskErr;

  // Reference mask computed straight from MB/ME with PowerPC MASK() wrap
  // semantics, independent of the begin/end/carry encoding above.
  always_comb begin
    w_chkMask = '0;
    for (int i = 0; i < 32; i++) begin
      w_chkMask[i] = ~r_s1Zero &
                     (w_wrap ? ((i[4:0] <= r_s1Me) || (i[4:0] >= r_s1Mb))
                             : ((i[4:0] >= r_s1Mb) && (i[4:0] <= r_s1Me)));
    end
  end

  // Any disagreement while stage 1 is valid latches the error until reset.
  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      r_mskErr <= 1'b0;
    end else if (r_s1Vld && (w_chkMask != ~seqIf.notMask)) begin
      r_mskErr <= 1'b1;
    end
  end

  assign mskErr = r_mskErr;
`endif

endmodule

// File: tb/tb_p405s_srm_mask_seq.sv
// ---------------------------------------------------------------------------
// tb_p405s_srm_mask_seq
//   Bench for p405s_srm_mask_seq. Includes a behavioural model of the external
//   mask-propagate block, a table of single-op vectors, and hand-written
//   sequences for hold/back-pressure, flush, async reset and (when
//   P405S_SRM_MASK_CHK_EN is defined) the mask checker. Results are checked
//   through an in-order scoreboard filled on accept.
// ---------------------------------------------------------------------------
module tb_p405s_srm_mask_seq;

  logic CB;
  logic resetL;
`ifdef P405S_SRM_MASK_CHK_EN
  logic mskErr;
`endif

  p405s_srm_mask_seq_if sif ();

  p405s_srm_mask_seq dut (
    .CB     (CB),
    .resetL (resetL),
`ifdef P405S_SRM_MASK_CHK_EN
    .mskErr (mskErr),
`endif
    .seqIf  (sif.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  mb;
    logic [4:0]  me;
    logic [5:0]  sh;
    int          begIdx;
    int          endIdx;
    logic [1:0]  la;
    logic [31:0] mask;
    logic        sra;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] mask;
    logic        sra;
    logic        zero;
  } exp_t;

  vec_t        vecs[14];
  exp_t        sbQ[$];
  exp_t        monE;
  int          compCount;
  int          failCount;
  int          emitted;
  logic [31:0] corruptMask;

  logic [0:31] mbEnd;
  logic [0:31] mbMask;
  logic        mbC;

  initial begin
    CB = 1'b0;
    forever #5 CB = ~CB;
  end

  // Model of the mask-propagate block: each half-word starts from its
  // look-ahead carry, turns on at the begin bit and off after the end bit.
  always_comb begin
    mbEnd         = '0;
    mbEnd[0:14]   = sif.mskEndHi;
    mbEnd[16:30]  = sif.mskEndLo;
    mbMask        = '0;
    mbC           = 1'b0;
    for (int h = 0; h < 2; h++) begin
      mbC = sif.propLookAhd[h];
      for (int j = 0; j < 16; j++) begin
        if (sif.mskBegin[h*16+j]) mbC = 1'b1;
        mbMask[h*16+j] = mbC;
        if (mbEnd[h*16+j]) mbC = 1'b0;
      end
    end
    sif.notMask = ~mbMask ^ corruptMask;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference MASK(MB,ME) derived from the op encoding.
  function automatic logic [0:31] maskModel(input logic [1:0] op, input logic [4:0] mb,
                                           input logic [4:0] me, input logic [5:0] sh);
    logic [4:0]  b;
    logic [4:0]  e;
    logic        z;
    logic [0:31] m;
    b = mb;
    e = me;
    z = 1'b0;
    if (op == 2'b01) begin
      b = 5'd0;
      e = 5'd31 - sh[4:0];
      z = sh[5];
    end else if (op != 2'b00) begin
      b = sh[4:0];
      e = 5'd31;
      z = sh[5];
    end
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (!z) m[i] = (b <= e) ? (i >= int'(b) && i <= int'(e)) : (i <= int'(e) || i >= int'(b));
    end
    return m;
  endfunction

  // Scoreboard consumer: a result leaves when valid and not held.
  always begin
    @(negedge CB);
    #2;
    if (resetL && sif.rsltVld && !sif.rsltHold) begin
      if (sbQ.size() == 0) begin
        compCount++;
        failCount++;
        $display("[TB] FAIL unexpected result: got mask %h, expected no result", sif.rsltMask);
      end else begin
        monE = sbQ.pop_front();
        emitted++;
        checkOutput("sb mask", 32'(sif.rsltMask), monE.mask);
        checkOutput("sb sraFill", 32'(sif.rsltSraFill), 32'(monE.sra));
        checkOutput("sb zero", 32'(sif.rsltZero), 32'(monE.zero));
      end
    end
  end

  // Offer one op in one cycle; reports whether it was taken.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] mb, input logic [4:0] me,
                               input logic [5:0] sh, input exp_t e, output bit acc);
    @(negedge CB);
    sif.reqVld = 1'b1;
    sif.reqOp  = op;
    sif.reqMb  = mb;
    sif.reqMe  = me;
    sif.reqSh  = sh;
    #1;
    acc = sif.reqRdy && !sif.flush;
    if (acc) sbQ.push_back(e);
  endtask

  task automatic sendOp(input logic [1:0] op, input logic [4:0] mb, input logic [4:0] me,
                        input logic [5:0] sh, input exp_t e);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      applyStimulus(op, mb, me, sh, e, acc);
      tries++;
    end
    if (!acc) begin
      compCount++;
      failCount++;
      $display("[TB] FAIL send timeout: got no accept, expected accept within 20 cycles");
    end
  endtask

  task automatic sendModel(input logic [1:0] op, input logic [4:0] mb, input logic [4:0] me,
                           input logic [5:0] sh);
    exp_t e;
    e.mask = maskModel(op, mb, me, sh) ^ corruptMask;
    e.sra  = (op == 2'b11);
    e.zero = (op != 2'b00) && sh[5];
    sendOp(op, mb, me, sh, e);
  endtask

  task automatic idle();
    @(negedge CB);
    sif.reqVld = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 20) begin
      @(negedge CB);
      n++;
    end
    @(negedge CB);
    #3;
    checkOutput("drain", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:31]  expBeg;
    logic [0:14]  expHi;
    logic [16:30] expLo;
    exp_t         e;
    int           startEmit;
    int           waited;

    compCount   = 0;
    failCount   = 0;
    emitted     = 0;
    corruptMask = '0;
    resetL      = 1'b0;
    sif.reqVld  = 1'b0;
    sif.reqOp   = '0;
    sif.reqMb   = '0;
    sif.reqMe   = '0;
    sif.reqSh   = '0;
    sif.flush   = 1'b0;
    sif.rsltHold = 1'b0;

    vecs[0]  = '{2'b00, 5'd0,  5'd31, 6'd0,  0,  31, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 5'd28, 5'd3,  6'd0,  28, 3,  2'b10, 32'hF000000F, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 5'd16, 5'd16, 6'd0,  16, 16, 2'b00, 32'h00008000, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 5'd0,  5'd0,  6'd4,  0,  27, 2'b01, 32'hFFFFFFF0, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 5'd0,  5'd0,  6'd40, -1, 31, 2'b00, 32'h00000000, 1'b0, 1'b1};
    vecs[5]  = '{2'b11, 5'd0,  5'd0,  6'd8,  8,  31, 2'b01, 32'h00FFFFFF, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 5'd20, 5'd15, 6'd0,  20, 15, 2'b10, 32'hFFFF0FFF, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 5'd31, 5'd31, 6'd0,  31, 31, 2'b00, 32'h00000001, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 5'd0,  5'd0,  6'd0,  0,  31, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 5'd0,  5'd0,  6'd31, 0,  0,  2'b00, 32'h80000000, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 5'd0,  5'd0,  6'd32, -1, 31, 2'b00, 32'h00000000, 1'b0, 1'b1};
    vecs[11] = '{2'b00, 5'd16, 5'd5,  6'd0,  16, 5,  2'b10, 32'hFC00FFFF, 1'b0, 1'b0};
    vecs[12] = '{2'b11, 5'd0,  5'd0,  6'd63, -1, 31, 2'b00, 32'h00000000, 1'b1, 1'b1};
    vecs[13] = '{2'b00, 5'd3,  5'd20, 6'd0,  3,  20, 2'b01, 32'h1FFFF800, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(negedge CB);
    #1;
    checkOutput("reset reqRdy", 32'(sif.reqRdy), 32'd0);
    checkOutput("reset rsltVld", 32'(sif.rsltVld), 32'd0);
    checkOutput("reset rsltMask", 32'(sif.rsltMask), 32'd0);
    checkOutput("reset mskBegin", 32'(sif.mskBegin), 32'd0);
    checkOutput("reset propLookAhd", 32'(sif.propLookAhd), 32'd0);
`ifdef P405S_SRM_MASK_CHK_EN
    checkOutput("reset mskErr", 32'(mskErr), 32'd0);
`endif
    @(negedge CB);
    resetL = 1'b1;
    @(negedge CB);
    #1;
    checkOutput("post-reset reqRdy", 32'(sif.reqRdy), 32'd1);

    // Table of single ops: stage-1 encoding one cycle after accept, result
    // valid two cycles after accept.
    $display("[TB] table vectors");
    for (int k = 0; k < 14; k++) begin
      e.mask = vecs[k].mask;
      e.sra  = vecs[k].sra;
      e.zero = vecs[k].zero;
      sendOp(vecs[k].op, vecs[k].mb, vecs[k].me, vecs[k].sh, e);
      @(negedge CB);
      sif.reqVld = 1'b0;
      #1;
      expBeg = '0;
      expHi  = '0;
      expLo  = '0;
      if (vecs[k].begIdx >= 0) expBeg[vecs[k].begIdx] = 1'b1;
      if (vecs[k].endIdx < 15) expHi[vecs[k].endIdx] = 1'b1;
      if (vecs[k].endIdx >= 16 && vecs[k].endIdx < 31) expLo[vecs[k].endIdx] = 1'b1;
      checkOutput($sformatf("vec%0d mskBegin", k), 32'(sif.mskBegin), 32'(expBeg));
      checkOutput($sformatf("vec%0d mskEndHi", k), 32'(sif.mskEndHi), 32'(expHi));
      checkOutput($sformatf("vec%0d mskEndLo", k), 32'(sif.mskEndLo), 32'(expLo));
      checkOutput($sformatf("vec%0d propLookAhd", k), 32'(sif.propLookAhd), 32'(vecs[k].la));
      checkOutput($sformatf("vec%0d rsltVld early", k), 32'(sif.rsltVld), 32'd0);
      @(negedge CB);
      #3;
      checkOutput($sformatf("vec%0d rsltVld at +2", k), 32'(sif.rsltVld), 32'd1);
    end
    waitDrain();

    // Back-to-back ops with a 3-cycle hold after the first result.
    $display("[TB] hold sequence");
    startEmit = emitted;
    fork
      begin
        sendModel(2'b00, 5'd0, 5'd7, 6'd0);
        sendModel(2'b00, 5'd8, 5'd15, 6'd0);
        sendModel(2'b01, 5'd0, 5'd0, 6'd16);
        sendModel(2'b11, 5'd0, 5'd0, 6'd24);
        idle();
      end
      begin
        waited = 0;
        while (!sif.rsltVld && waited < 10) begin
          @(negedge CB);
          waited++;
        end
        checkOutput("first result seen", 32'(sif.rsltVld), 32'd1);
        sif.rsltHold = 1'b1;
        for (int c = 0; c < 3; c++) begin
          #1;
          checkOutput($sformatf("reqRdy full stall %0d", c), 32'(sif.reqRdy), 32'd0);
          checkOutput($sformatf("held mask stable %0d", c), 32'(sif.rsltMask), 32'hFF000000);
          @(negedge CB);
        end
        sif.rsltHold = 1'b0;
      end
    join
    waitDrain();
    checkOutput("hold seq emitted", 32'(emitted - startEmit), 32'd4);

    // Flush with both stages full (result held) and a new request pending.
    $display("[TB] flush sequence");
    sif.rsltHold = 1'b1;
    sendModel(2'b00, 5'd4, 5'd9, 6'd0);
    sendModel(2'b10, 5'd0, 5'd0, 6'd12);
    @(negedge CB);
    sif.flush  = 1'b1;
    sif.reqVld = 1'b1;
    sif.reqOp  = 2'b00;
    sif.reqMb  = 5'd0;
    sif.reqMe  = 5'd31;
    #1;
    checkOutput("flush pre rsltVld", 32'(sif.rsltVld), 32'd1);
    @(negedge CB);
    sif.flush    = 1'b0;
    sif.reqVld   = 1'b0;
    sif.rsltHold = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("flush rsltVld", 32'(sif.rsltVld), 32'd0);
    checkOutput("flush mskBegin", 32'(sif.mskBegin), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CB);
      #1;
      checkOutput($sformatf("post-flush rsltVld %0d", c), 32'(sif.rsltVld), 32'd0);
    end

    // Flush on an empty pipe drops a request that ready would have taken.
    @(negedge CB);
    sif.flush  = 1'b1;
    sif.reqVld = 1'b1;
    sif.reqOp  = 2'b00;
    sif.reqMb  = 5'd0;
    sif.reqMe  = 5'd31;
    #1;
    checkOutput("flush-accept reqRdy", 32'(sif.reqRdy), 32'd1);
    @(negedge CB);
    sif.flush  = 1'b0;
    sif.reqVld = 1'b0;
    #1;
    checkOutput("flush-accept dropped begin", 32'(sif.mskBegin), 32'd0);
    checkOutput("flush-accept dropped la", 32'(sif.propLookAhd), 32'd0);
    @(negedge CB);
    #1;
    checkOutput("flush-accept no result", 32'(sif.rsltVld), 32'd0);

`ifdef P405S_SRM_MASK_CHK_EN
    checkOutput("mskErr clean traffic", 32'(mskErr), 32'd0);
`endif

    // Async reset in the middle of traffic.
    $display("[TB] reset sequence");
    sendModel(2'b11, 5'd0, 5'd0, 6'd4);
    sendModel(2'b00, 5'd3, 5'd20, 6'd0);
    @(negedge CB);
    sif.reqVld = 1'b0;
    #3;
    resetL = 1'b0;
    #1;
    sbQ.delete();
    checkOutput("async rst rsltVld", 32'(sif.rsltVld), 32'd0);
    checkOutput("async rst rsltMask", 32'(sif.rsltMask), 32'd0);
    checkOutput("async rst sraFill", 32'(sif.rsltSraFill), 32'd0);
    checkOutput("async rst mskBegin", 32'(sif.mskBegin), 32'd0);
    checkOutput("async rst mskEndLo", 32'(sif.mskEndLo), 32'd0);
    checkOutput("async rst propLookAhd", 32'(sif.propLookAhd), 32'd0);
    checkOutput("async rst reqRdy", 32'(sif.reqRdy), 32'd0);
    @(negedge CB);
    resetL = 1'b1;
    @(negedge CB);
    #1;
    checkOutput("re-reset reqRdy", 32'(sif.reqRdy), 32'd1);
    checkOutput("re-reset rsltVld", 32'(sif.rsltVld), 32'd0);

`ifdef P405S_SRM_MASK_CHK_EN
    // Corrupt one returned mask bit while an op sits in stage 1.
    $display("[TB] checker sequence");
    corruptMask = 32'h00010000;
    sendModel(2'b00, 5'd0, 5'd31, 6'd0);
    idle();
    @(negedge CB);
    #3;
    corruptMask = '0;
    checkOutput("mskErr set", 32'(mskErr), 32'd1);
    sendModel(2'b00, 5'd2, 5'd9, 6'd0);
    idle();
    waitDrain();
    checkOutput("mskErr sticky", 32'(mskErr), 32'd1);
`endif

    waitDrain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
